// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout for a 1024x768 timing generator: fetches each low-res row one line ahead
// into a ping-pong line buffer and replicates pixels SCALE x SCALE onto a 2-stage RGB pipeline.
module vga_fb_scanout #(
  parameter int unsigned FB_W       = 256,
  parameter int unsigned FB_H       = 192,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned V_TOTAL    = 806,
  parameter logic [19:0] BASE_ADDR  = 20'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        h_sync,
  output logic        v_sync,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        underrun
);

  localparam int unsigned ColW = $clog2(FB_W);
  localparam int unsigned RowW = $clog2(FB_H);
  localparam logic [10:0] VisW    = 11'(FB_W << SCALE_LOG2);
  localparam logic [10:0] VisH    = 11'(FB_H << SCALE_LOG2);
  localparam logic [10:0] SubMask = 11'((1 << SCALE_LOG2) - 1);
  localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(FB_W - 1);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic            bank_q;
  logic [10:0]     next_line;
  logic            trigger;
  logic [RowW-1:0] tgt_row;
  logic            ack_ok;

  // Fetch the row that becomes visible on the next line, once per SCALE lines.
  always_comb begin
    next_line = (v_count == VLast) ? 11'd0 : v_count + 11'd1;
    trigger   = (h_count == 11'd0) && (next_line < VisH) && ((next_line & SubMask) == 11'd0);
    tgt_row   = RowW'(next_line >> SCALE_LOG2);
  end

  assign ack_ok = mem_req && mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      bank_q   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      underrun <= 1'b0;
    end else if (trigger) begin
      // A new trigger always wins; an unfinished row is abandoned.
      if (state_q == StFetch) underrun <= 1'b1;
      state_q  <= StFetch;
      col_q    <= '0;
      bank_q   <= tgt_row[0];
      mem_req  <= 1'b1;
      mem_addr <= BASE_ADDR + 20'(tgt_row) * 20'(FB_W);
    end else if (ack_ok) begin
      col_q    <= col_q + ColW'(1);
      mem_addr <= mem_addr + 20'd1;
      if (col_q == ColLast) begin
        state_q <= StIdle;
        mem_req <= 1'b0;
      end
    end
  end

  logic [11:0]     lbuf [2*FB_W];
  logic [ColW-1:0] rd_col;
  logic            rd_bank;
  logic [11:0]     rd_data;
  logic            vis;
  logic            vis_q;
  logic            hs_q;
  logic            vs_q;

  assign rd_col  = ColW'(h_count >> SCALE_LOG2);
  assign rd_bank = v_count[SCALE_LOG2];
  assign vis     = (h_count < VisW) && (v_count < VisH);

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ack_ok && !rst) lbuf[{bank_q, col_q}] <= mem_rdata[11:0];
    rd_data <= lbuf[{rd_bank, rd_col}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vis_q     <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      h_sync    <= 1'b0;
      v_sync    <= 1'b0;
      {r, g, b} <= 12'h000;
    end else begin
      vis_q     <= vis;
      hs_q      <= h_sync_in;
      vs_q      <= v_sync_in;
      h_sync    <= hs_q;
      v_sync    <= vs_q;
      {r, g, b} <= vis_q ? rd_data : 12'h000;
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[15:12];

endmodule
